freq_pair_reader: RTL and testbench

- Consumer end of the frequency FIFO path. It pops matched (reference, song) frequency pairs from the two frequency FIFOs, which are written by the FFT stage or the simulated loader.
- Each pair goes to the scoring module over a valid/ready handshake, together with the signed and absolute frequency difference.
- It counts consumed pairs, pulses done at the end of a run, and flags FIFO skew, i.e. one FIFO holding data while the other stays empty.

---
 rtl/freq_pkg.sv | 24 ++
 rtl/freq_skew_watchdog.sv | 33 +++
 rtl/freq_pair_reader.sv | 139 +++++++++++++
 tb/tb_freq_pair_reader.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared definitions for the frequency-pair read path: default word width,
// FSM state encoding and the frequency / difference word types.
package freq_pkg;

   localparam int FREQ_W_DEF = 15;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_POP     = 3'd1;
   localparam logic [2:0] ST_WAIT    = 3'd2;
   localparam logic [2:0] ST_PRESENT = 3'd3;
   localparam logic [2:0] ST_FINISH  = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      POP     = ST_POP,
      WAIT    = ST_WAIT,
      PRESENT = ST_PRESENT,
      FINISH  = ST_FINISH
   } state_t;

   typedef logic [FREQ_W_DEF-1:0] freq_t;
   typedef logic [FREQ_W_DEF:0]   diff_t;

endpackage

// File: rtl/freq_skew_watchdog.sv
// Trips for one cycle once exactly one of the two FIFOs has been empty for
// SKEW_LIMIT consecutive enabled cycles; both-empty is an ordinary stall.
module freq_skew_watchdog #(
   parameter int SKEW_LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic ref_empty,
   input  logic song_empty,
   output logic trip
);

   localparam int CW = $clog2(SKEW_LIMIT + 1);

   logic [CW-1:0] run_cnt;
   logic          skewed;

   assign skewed = enable && (ref_empty ^ song_empty);
   assign trip   = skewed && (run_cnt == CW'(SKEW_LIMIT - 1));

   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         run_cnt <= '0;
      else if (!skewed || trip)
         run_cnt <= '0;
      else
         run_cnt <= run_cnt + CW'(1);
   end

endmodule

// File: rtl/freq_pair_reader.sv
// Pops matched reference/song frequency pairs from two FIFOs and presents
// each with its signed and absolute difference over a valid/ready handshake.
module freq_pair_reader
   import freq_pkg::*;
#(
   parameter int FREQ_W     = FREQ_W_DEF,
   parameter int CNT_W      = 8,
   parameter int RD_LATENCY = 1,
   parameter int SKEW_LIMIT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_pairs,
   input  logic              ref_empty,
   input  logic              song_empty,
   input  logic [FREQ_W-1:0] ref_dout,
   input  logic [FREQ_W-1:0] song_dout,
   output logic              rd_en,
   output logic              pair_valid,
   input  logic              pair_ready,
   output logic [FREQ_W-1:0] ref_freq,
   output logic [FREQ_W-1:0] song_freq,
   output logic [FREQ_W:0]   diff,
   output logic [FREQ_W-1:0] abs_diff,
   output logic [CNT_W-1:0]  pair_index,
   output logic              busy,
   output logic              done,
   output logic              skew_err
);

   state_t             state, state_nx;
   logic [CNT_W-1:0]   num_q, cnt_q, cnt_inc;
   logic [1:0]         wait_cnt;
   logic               trip;
   logic               start_acc, capture, accept;
   logic [FREQ_W:0]    diff_c;
   logic [FREQ_W-1:0]  abs_c;

   // Zero-extending both operands makes the subtraction overflow-free, and the
   // magnitude always fits back into FREQ_W bits.
   assign diff_c  = {1'b0, song_dout} - {1'b0, ref_dout};
   assign abs_c   = diff_c[FREQ_W] ? FREQ_W'(-diff_c) : diff_c[FREQ_W-1:0];
   assign cnt_inc = cnt_q + CNT_W'(1);

   freq_skew_watchdog #(
      .SKEW_LIMIT(SKEW_LIMIT)
   ) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .enable    (state == POP),
      .ref_empty (ref_empty),
      .song_empty(song_empty),
      .trip      (trip)
   );

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_nx  = state;
      rd_en     = 1'b0;
      start_acc = 1'b0;
      capture   = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               state_nx  = (num_pairs == '0) ? FINISH : POP;
            end
         end
         POP: begin
            if (trip)
               state_nx = FINISH;
            else if (!ref_empty && !song_empty) begin
               rd_en    = 1'b1;
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (wait_cnt == 2'(RD_LATENCY - 1)) begin
               capture  = 1'b1;
               state_nx = PRESENT;
            end
         end
         PRESENT: begin
            if (pair_ready) begin
               accept   = 1'b1;
               state_nx = (cnt_inc == num_q) ? FINISH : POP;
            end
         end
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign pair_valid = (state == PRESENT);
   assign busy       = (state != IDLE);
   assign done       = (state == FINISH);
   assign pair_index = cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
         num_q    <= '0;
         cnt_q    <= '0;
         skew_err <= 1'b0;
      end else begin
         state    <= state_nx;
         wait_cnt <= (state == WAIT) ? wait_cnt + 2'd1 : 2'd0;
         if (start_acc) begin
            num_q    <= num_pairs;
            cnt_q    <= '0;
            skew_err <= 1'b0;
         end else begin
            if (accept) cnt_q    <= cnt_inc;
            if (trip)   skew_err <= 1'b1;
         end
      end
   end

   // Presented data is frozen between capture and the next capture, which
   // keeps it stable through any amount of backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_freq  <= '0;
         song_freq <= '0;
         diff      <= '0;
         abs_diff  <= '0;
      end else if (capture) begin
         ref_freq  <= ref_dout;
         song_freq <= song_dout;
         diff      <= diff_c;
         abs_diff  <= abs_c;
      end
   end

endmodule

// File: tb/tb_freq_pair_reader.sv
// Directed bench for freq_pair_reader: behavioural FIFOs feed two instances
// (read latency 1 and 2); a scoreboard holds the expected pairs.
module tb_freq_pair_reader;
   import freq_pkg::*;

   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [CNT_W-1:0] num_pairs = '0;

   logic              start1 = 1'b0, ready1 = 1'b0;
   logic              rempty1 = 1'b1, sempty1 = 1'b1;
   freq_t             rdout1 = '0, sdout1 = '0;
   logic              rd_en1, valid1, busy1, done1, skew1;
   freq_t             rfreq1, sfreq1, abs1;
   logic signed [15:0] diff1;
   logic [CNT_W-1:0]  idx1;

   logic              start2 = 1'b0, ready2 = 1'b0;
   logic              rempty2 = 1'b1, sempty2 = 1'b1;
   freq_t             rdout2 = '0, sdout2 = '0, rstage2 = '0, sstage2 = '0;
   logic              rd_en2, valid2, busy2, done2, skew2;
   freq_t             rfreq2, sfreq2, abs2;
   logic signed [15:0] diff2;
   logic [CNT_W-1:0]  idx2;

   freq_pair_reader #(.FREQ_W(15), .CNT_W(CNT_W), .RD_LATENCY(1), .SKEW_LIMIT(16)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .num_pairs(num_pairs),
      .ref_empty(rempty1), .song_empty(sempty1), .ref_dout(rdout1), .song_dout(sdout1),
      .rd_en(rd_en1), .pair_valid(valid1), .pair_ready(ready1),
      .ref_freq(rfreq1), .song_freq(sfreq1), .diff(diff1), .abs_diff(abs1),
      .pair_index(idx1), .busy(busy1), .done(done1), .skew_err(skew1)
   );

   freq_pair_reader #(.FREQ_W(15), .CNT_W(CNT_W), .RD_LATENCY(2), .SKEW_LIMIT(16)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .num_pairs(num_pairs),
      .ref_empty(rempty2), .song_empty(sempty2), .ref_dout(rdout2), .song_dout(sdout2),
      .rd_en(rd_en2), .pair_valid(valid2), .pair_ready(ready2),
      .ref_freq(rfreq2), .song_freq(sfreq2), .diff(diff2), .abs_diff(abs2),
      .pair_index(idx2), .busy(busy2), .done(done2), .skew_err(skew2)
   );

   // Behavioural FIFOs; empty flags follow pushes at the next rising edge.
   freq_t rq1[$], sq1[$], rq2[$], sq2[$];
   int    cyc = 0, rd_cnt1 = 0, done_cnt1 = 0;

   always @(posedge clk) begin
      cyc++;
      if (rd_en1) rd_cnt1++;
      if (done1)  done_cnt1++;
      if (rd_en1 && rq1.size() > 0 && sq1.size() > 0) begin
         rdout1 <= rq1.pop_front();
         sdout1 <= sq1.pop_front();
      end
      if (rd_en2 && rq2.size() > 0 && sq2.size() > 0) begin
         rstage2 <= rq2.pop_front();
         sstage2 <= sq2.pop_front();
      end
      rdout2  <= rstage2;
      sdout2  <= sstage2;
      rempty1 <= (rq1.size() == 0);
      sempty1 <= (sq1.size() == 0);
      rempty2 <= (rq2.size() == 0);
      sempty2 <= (sq2.size() == 0);
   end

   typedef struct {
      freq_t r;
      freq_t s;
      int    d;
      int    a;
      int    idx;
   } exp_t;

   typedef struct {
      logic               valid, done, rd_en, busy, skew;
      freq_t              rf, sf, a;
      logic signed [15:0] d;
      logic [CNT_W-1:0]   idx;
   } obs_t;

   exp_t sb1[$], sb2[$];
   int   n_tests = 0, n_fail = 0;

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic exp_t make_exp(input freq_t r, input freq_t s, input int idx);
      exp_t e;
      e.r   = r;
      e.s   = s;
      e.d   = int'(s) - int'(r);
      e.a   = (e.d < 0) ? -e.d : e.d;
      e.idx = idx;
      return e;
   endfunction

   task automatic load(input int sel, input freq_t r, input freq_t s, input int idx);
      if (sel == 2) begin
         rq2.push_back(r); sq2.push_back(s); sb2.push_back(make_exp(r, s, idx));
      end else begin
         rq1.push_back(r); sq1.push_back(s); sb1.push_back(make_exp(r, s, idx));
      end
   endtask

   function automatic obs_t snap(input int sel);
      obs_t o;
      if (sel == 2) begin
         o.valid = valid2; o.done = done2; o.rd_en = rd_en2; o.busy = busy2; o.skew = skew2;
         o.rf = rfreq2; o.sf = sfreq2; o.a = abs2; o.d = diff2; o.idx = idx2;
      end else begin
         o.valid = valid1; o.done = done1; o.rd_en = rd_en1; o.busy = busy1; o.skew = skew1;
         o.rf = rfreq1; o.sf = sfreq1; o.a = abs1; o.d = diff1; o.idx = idx1;
      end
      return o;
   endfunction

   // All tasks below are entered and left on a falling edge.
   task automatic start_run(input int sel, input int n);
      num_pairs = CNT_W'(n);
      if (sel == 2) start2 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      start2 = 1'b0;
   endtask

   task automatic get_pair(input int sel, input string tag);
      obs_t o;
      exp_t e;
      int   k = 0;
      o = snap(sel);
      while (o.valid !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
         o = snap(sel);
      end
      check({tag, ".valid"}, 32'(o.valid), 1);
      if (o.valid === 1'b1) begin
         if ((sel == 2) ? (sb2.size() == 0) : (sb1.size() == 0)) begin
            check({tag, ".sb_underflow"}, 0, 1);
         end else begin
            e = (sel == 2) ? sb2.pop_front() : sb1.pop_front();
            check({tag, ".ref_freq"},   o.rf,  e.r);
            check({tag, ".song_freq"},  o.sf,  e.s);
            check({tag, ".diff"},       o.d,   e.d);
            check({tag, ".abs_diff"},   o.a,   e.a);
            check({tag, ".pair_index"}, o.idx, e.idx);
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_done(input int sel, input string tag);
      obs_t o;
      int   k = 0;
      o = snap(sel);
      while (o.done !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
         o = snap(sel);
      end
      check({tag, ".done"}, 32'(o.done), 1);
      @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   r0, d0, bad, k, t0;
      exp_t e;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst.rd_en",      32'(rd_en1), 0);
      check("rst.pair_valid", 32'(valid1), 0);
      check("rst.busy",       32'(busy1),  0);
      check("rst.done",       32'(done1),  0);
      check("rst.skew_err",   32'(skew1),  0);
      check("rst.pair_index", idx1,  0);
      check("rst.ref_freq",   rfreq1, 0);
      check("rst.diff",       diff1,  0);
      rst = 1'b0;
      @(negedge clk);

      // Nominal run, ready held high
      r0 = rd_cnt1;
      d0 = done_cnt1;
      load(1, 440, 440, 0);
      load(1, 440, 329, 1);
      load(1, 440, 390, 2);
      load(1, 440, 448, 3);
      load(1, 440, 462, 4);
      load(1, 440, 466, 5);
      ready1 = 1'b1;
      start_run(1, 6);
      for (int i = 0; i < 6; i++) get_pair(1, "nominal");
      wait_done(1, "nominal");
      check("nominal.busy_low",  32'(busy1), 0);
      check("nominal.rd_pulses", rd_cnt1 - r0, 6);
      check("nominal.done_cnt",  done_cnt1 - d0, 1);

      // Backpressure on pair 1, plus full-scale differences
      load(1, 1000,  1200,  0);
      load(1, 2000,  1500,  1);
      load(1, 32767, 0,     2);
      load(1, 0,     32767, 3);
      start_run(1, 4);
      get_pair(1, "bp");
      ready1 = 1'b0;
      k = 0;
      while (valid1 !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      check("bp.valid_seen", 32'(valid1), 1);
      e   = sb1[0];
      r0  = rd_cnt1;
      bad = 0;
      repeat (5) begin
         if (valid1 !== 1'b1 || rfreq1 !== e.r || sfreq1 !== e.s ||
             int'(diff1) != e.d || int'(abs1) != e.a || int'(idx1) != e.idx) bad++;
         @(negedge clk);
      end
      check("bp.stable_cycles", bad, 0);
      check("bp.no_rd_en", rd_cnt1 - r0, 0);
      ready1 = 1'b1;
      for (int i = 0; i < 3; i++) get_pair(1, "bp");
      wait_done(1, "bp");

      // Both FIFOs empty: a plain stall, never an error
      start_run(1, 2);
      bad = 0;
      repeat (40) begin
         if (rd_en1 !== 1'b0 || skew1 !== 1'b0 || busy1 !== 1'b1) bad++;
         @(negedge clk);
      end
      check("stall.quiet_cycles", bad, 0);
      load(1, 523, 494, 0);
      load(1, 100, 200, 1);
      get_pair(1, "stall");
      get_pair(1, "stall");
      wait_done(1, "stall");
      check("stall.skew_err", 32'(skew1), 0);

      // Skew: reference holds data, song stays empty
      r0 = rd_cnt1;
      rq1.push_back(777);
      start_run(1, 1);
      k = 0;
      while (done1 !== 1'b1 && k < 100) begin @(negedge clk); k++; end
      check("skew.cycles_to_done", k, 16);
      check("skew.skew_err",  32'(skew1), 1);
      check("skew.no_rd_en",  rd_cnt1 - r0, 0);
      @(negedge clk);
      check("skew.sticky",    32'(skew1), 1);
      check("skew.idle",      32'(busy1), 0);
      sq1.push_back(888);
      sb1.push_back(make_exp(777, 888, 0));
      start_run(1, 1);
      check("skew.cleared_on_start", 32'(skew1), 0);
      get_pair(1, "skew_rerun");
      wait_done(1, "skew_rerun");

      // num_pairs = 0
      r0 = rd_cnt1;
      start_run(1, 0);
      check("zero.done",      32'(done1), 1);
      check("zero.busy",      32'(busy1), 1);
      @(negedge clk);
      check("zero.done_drop", 32'(done1), 0);
      check("zero.busy_drop", 32'(busy1), 0);
      check("zero.no_rd_en",  rd_cnt1 - r0, 0);

      // Reset while a pair is presented
      load(1, 5000, 4000, 0);
      ready1 = 1'b0;
      start_run(1, 1);
      k = 0;
      while (valid1 !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      check("rstmid.valid_seen", 32'(valid1), 1);
      rst = 1'b1;
      #1;
      check("rstmid.pair_valid", 32'(valid1), 0);
      check("rstmid.busy",       32'(busy1),  0);
      check("rstmid.rd_en",      32'(rd_en1), 0);
      void'(sb1.pop_front());
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rstmid.idle_busy",  32'(busy1),  0);
      check("rstmid.idle_valid", 32'(valid1), 0);
      check("rstmid.pair_index", idx1, 0);
      ready1 = 1'b1;
      check("sb1.drained", sb1.size(), 0);

      // Read latency 2 on the second instance
      load(2, 440, 466, 0);
      load(2, 466, 440, 1);
      ready2 = 1'b1;
      start_run(2, 2);
      k = 0;
      while (rd_en2 !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      check("lat2.rd_en_seen", 32'(rd_en2), 1);
      t0 = cyc;
      k  = 0;
      while (valid2 !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      check("lat2.first_valid_offset", cyc - t0, 3);
      get_pair(2, "lat2");
      get_pair(2, "lat2");
      wait_done(2, "lat2");
      check("sb2.drained", sb2.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
